// File: rtl/fa_bist.sv
// ----------------------------------------------------------------------------
// fa_bist -- built-in self test sequencer for an external 1-bit full adder.
//
// A run steps a 3-bit vector {cin,b,a} through 0..7, PASSES times over. Each
// vector is held for SETTLE_CYCLES cycles (DRIVE) and then for one more cycle
// (SAMPLE). At the closing edge of SAMPLE the adder response is compared with
// the ideal sum/carry. Any mismatching sample adds one to a saturating error
// count.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector settles before sampling (1..15)
//   PASSES         full 8-vector sweeps per run (1..15)
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             single-cycle run request, honoured in IDLE or DONE only
//   fa_a/fa_b/fa_cin  stimulus to the adder under test
//   fa_sum/fa_cout    response from the adder under test
//   busy              run in progress (DRIVE or SAMPLE)
//   done              run finished, held until the next accepted start
//   pass              done with zero mismatches
//   err_cnt           mismatching samples in the current or last run
//   first_fail_vec    {cin,b,a} of the first mismatch  (FA_BIST_ERRLOG_EN)
//   first_fail_valid  first_fail_vec holds a capture    (FA_BIST_ERRLOG_EN)
//
// Optional feature: define FA_BIST_ERRLOG_EN to add first-failure capture.
// ----------------------------------------------------------------------------
module fa_bist #(
   parameter int SETTLE_CYCLES = 1,
   parameter int PASSES        = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       fa_a,
   output logic       fa_b,
   output logic       fa_cin,
   input  logic       fa_sum,
   input  logic       fa_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_cnt
`ifdef FA_BIST_ERRLOG_EN
   ,
   output logic [2:0] first_fail_vec,
   output logic       first_fail_valid
`endif
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] vec;
   logic [3:0] pass_cnt;
   logic [3:0] settle_cnt;
   logic       settle_last;
   logic       run_last;
   logic       start_ok;
   logic       exp_sum;
   logic       exp_cout;
   logic       mismatch;

   assign start_ok    = start && (state == IDLE || state == DONE);
   assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
   assign run_last    = (vec == 3'd7) && (pass_cnt == 4'(PASSES - 1));

   // Reference full adder; one sample counts once even if both bits are wrong.
   assign exp_sum  = vec[0] ^ vec[1] ^ vec[2];
   assign exp_cout = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
   assign mismatch = (fa_sum != exp_sum) || (fa_cout != exp_cout);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: DRIVE counts out the settle time, SAMPLE is a single
   // cycle, and the final SAMPLE of the last pass lands in DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = DRIVE;
         DRIVE:      if (settle_last) state_nxt = SAMPLE;
         SAMPLE:     state_nxt = run_last ? DONE : DRIVE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Datapath: counters and error tally. The vector is left at 7 after the
   // last sample so DONE keeps presenting it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec        <= '0;
         pass_cnt   <= '0;
         settle_cnt <= '0;
         err_cnt    <= '0;
      end else if (start_ok) begin
         vec        <= '0;
         pass_cnt   <= '0;
         settle_cnt <= '0;
         err_cnt    <= '0;
      end else if (state == DRIVE) begin
         settle_cnt <= settle_last ? 4'd0 : settle_cnt + 4'd1;
      end else if (state == SAMPLE) begin
         if (mismatch && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
         if (!run_last) begin
            vec <= vec + 3'd1;
            if (vec == 3'd7) begin
               pass_cnt <= pass_cnt + 4'd1;
            end
         end
      end
   end

`ifdef FA_BIST_ERRLOG_EN
   // First-failure capture: only the earliest mismatching sample of a run is
   // kept; a new accepted start rearms it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (start_ok) begin
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (state == SAMPLE && mismatch && !first_fail_valid) begin
         first_fail_vec   <= vec;
         first_fail_valid <= 1'b1;
      end
   end
`endif

   assign busy   = (state == DRIVE) || (state == SAMPLE);
   assign done   = (state == DONE);
   assign pass   = done && (err_cnt == 8'd0);
   assign fa_a   = (state != IDLE) && vec[0];
   assign fa_b   = (state != IDLE) && vec[1];
   assign fa_cin = (state != IDLE) && vec[2];

endmodule

// File: tb/tb_fa_bist.sv
// ----------------------------------------------------------------------------
// tb_fa_bist -- self-checking bench for fa_bist.
//
// Four DUT instances share clock and reset, each with its own parameter set
// and its own behavioural adder whose fault mode is chosen per run:
//   g=0: SETTLE_CYCLES=1, PASSES=1     g=1: SETTLE_CYCLES=1, PASSES=3
//   g=2: SETTLE_CYCLES=1, PASSES=15    g=3: SETTLE_CYCLES=3, PASSES=2
// Build with FA_BIST_ERRLOG_EN defined to include first-failure checks.
// ----------------------------------------------------------------------------
module tb_fa_bist;

   localparam int IDEAL    = 0;
   localparam int COUT_SA0 = 1;
   localparam int SUM_INV  = 2;
   localparam int BOTH_SA1 = 3;
   localparam int SUM_SA0  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] start;
   logic [3:0] fa_a, fa_b, fa_cin, fa_sum, fa_cout;
   logic [3:0] busy, done, pass;
   logic [7:0] err_cnt [4];
`ifdef FA_BIST_ERRLOG_EN
   logic [2:0] first_fail_vec [4];
   logic [3:0] first_fail_valid;
`endif
   int fault_mode [4];

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int   idx;
      int   mode;
      int   err;
      int   ff;
      logic ffv;
   } vec_t;

   typedef struct {
      int   idx;
      int   err;
      int   pass;
      int   ff;
      logic ffv;
      int   lat;
   } exp_t;

   exp_t sb [$];

   always #5 clk = ~clk;

   function automatic int settle_of(int g);
      return (g == 3) ? 3 : 1;
   endfunction

   function automatic int passes_of(int g);
      return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 15 : 2;
   endfunction

   // Behavioural adder with injectable faults.
   function automatic logic adder_sum(logic a, logic b, logic c, int mode);
      case (mode)
         SUM_INV:  return ~(a ^ b ^ c);
         BOTH_SA1: return 1'b1;
         SUM_SA0:  return 1'b0;
         default:  return a ^ b ^ c;
      endcase
   endfunction

   function automatic logic adder_cout(logic a, logic b, logic c, int mode);
      case (mode)
         COUT_SA0: return 1'b0;
         BOTH_SA1: return 1'b1;
         default:  return (a & b) | (a & c) | (b & c);
      endcase
   endfunction

   // DUT instances and their adders.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      fa_bist #(
         .SETTLE_CYCLES(g == 3 ? 3 : 1),
         .PASSES(g == 0 ? 1 : (g == 1 ? 3 : (g == 2 ? 15 : 2)))
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .start(start[g]),
         .fa_a(fa_a[g]),
         .fa_b(fa_b[g]),
         .fa_cin(fa_cin[g]),
         .fa_sum(fa_sum[g]),
         .fa_cout(fa_cout[g]),
         .busy(busy[g]),
         .done(done[g]),
         .pass(pass[g]),
         .err_cnt(err_cnt[g])
`ifdef FA_BIST_ERRLOG_EN
         ,
         .first_fail_vec(first_fail_vec[g]),
         .first_fail_valid(first_fail_valid[g])
`endif
      );
      assign fa_sum[g]  = adder_sum(fa_a[g], fa_b[g], fa_cin[g], fault_mode[g]);
      assign fa_cout[g] = adder_cout(fa_a[g], fa_b[g], fa_cin[g], fault_mode[g]);
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int stim(int idx);
      return int'({fa_cin[idx], fa_b[idx], fa_a[idx]});
   endfunction

   // Launch one run, follow it cycle by cycle, then pop and check the result.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      exp_t got;
      int   s;
      int   n;
      bit   seen;
      s     = settle_of(v.idx);
      e.idx = v.idx;
      e.err = v.err;
      e.pass = (v.err == 0) ? 1 : 0;
      e.ff  = v.ff;
      e.ffv = v.ffv;
      e.lat = 1 + passes_of(v.idx) * 8 * (s + 1);
      fault_mode[v.idx] = v.mode;
      sb.push_back(e);
      @(posedge clk);
      #1 start[v.idx] = 1'b1;
      @(posedge clk);
      #1 start[v.idx] = 1'b0;
      seen = 0;
      n    = -1;
      for (int i = 0; i < e.lat + 8; i++) begin
         @(negedge clk);
         if (done[v.idx]) begin
            seen = 1;
            n    = i;
            break;
         end
         if (i == 0) begin
            checkOutput("err_cleared", int'(err_cnt[v.idx]), 0);
            checkOutput("pass_low_busy", int'(pass[v.idx]), 0);
`ifdef FA_BIST_ERRLOG_EN
            checkOutput("ffv_cleared", int'(first_fail_valid[v.idx]), 0);
`endif
         end
         if (i < e.lat - 1) begin
            checkOutput("busy", int'(busy[v.idx]), 1);
            checkOutput("stim_vec", stim(v.idx), (i / (s + 1)) % 8);
         end
      end
      checkOutput("done_latency", seen ? n : -1, e.lat - 1);
      got = sb.pop_front();
      checkOutput("err_cnt", int'(err_cnt[got.idx]), got.err);
      checkOutput("pass", int'(pass[got.idx]), got.pass);
      checkOutput("busy_done", int'(busy[got.idx]), 0);
      checkOutput("stim_done", stim(got.idx), 7);
`ifdef FA_BIST_ERRLOG_EN
      checkOutput("ff_valid", int'(first_fail_valid[got.idx]), int'(got.ffv));
      if (got.ffv) checkOutput("ff_vec", int'(first_fail_vec[got.idx]), got.ff);
`endif
   endtask

   task automatic checkIdle(input string name, input int idx);
      checkOutput({name, "_busy"}, int'(busy[idx]), 0);
      checkOutput({name, "_done"}, int'(done[idx]), 0);
      checkOutput({name, "_pass"}, int'(pass[idx]), 0);
      checkOutput({name, "_err"}, int'(err_cnt[idx]), 0);
      checkOutput({name, "_stim"}, stim(idx), 0);
`ifdef FA_BIST_ERRLOG_EN
      checkOutput({name, "_ffv"}, int'(first_fail_valid[idx]), 0);
`endif
   endtask

   // Global watchdog.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t tbl [10];
      // Expected error counts per 8-vector sweep:
      //   cout stuck 0: vectors 3,5,6,7 -> 4, first 3
      //   sum inverted: all 8, first 0
      //   both stuck 1: only vector 7 is correct -> 7, first 0
      //   sum stuck 0:  vectors 1,2,4,7 -> 4, first 1
      tbl[0] = '{0, IDEAL,    0,   0, 1'b0};
      tbl[1] = '{0, COUT_SA0, 4,   3, 1'b1};
      tbl[2] = '{0, SUM_INV,  8,   0, 1'b1};
      tbl[3] = '{0, BOTH_SA1, 7,   0, 1'b1};
      tbl[4] = '{0, SUM_SA0,  4,   1, 1'b1};
      tbl[5] = '{1, SUM_INV,  24,  0, 1'b1};
      tbl[6] = '{3, IDEAL,    0,   0, 1'b0};
      tbl[7] = '{3, COUT_SA0, 8,   3, 1'b1};
      tbl[8] = '{2, BOTH_SA1, 105, 0, 1'b1};
      tbl[9] = '{2, IDEAL,    0,   0, 1'b0};

      for (int g = 0; g < 4; g++) fault_mode[g] = IDEAL;
      start = '0;
      rst_n = 1'b0;
      #3;
      for (int g = 0; g < 4; g++) checkIdle("reset", g);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 10; t++) applyStimulus(tbl[t]);

      // Mid-run: extra start ignored, then asynchronous reset at vector 4.
      $display("[TB] mid-run start and reset sequence");
      fault_mode[0] = COUT_SA0;
      @(posedge clk);
      #1 start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i == 2) start[0] = 1'b1;
         if (i == 3) start[0] = 1'b0;
         if (i == 4 || i == 8) begin
            checkOutput("midrun_busy", int'(busy[0]), 1);
            checkOutput("midrun_stim", stim(0), i / 2);
         end
      end
      checkOutput("midrun_err", int'(err_cnt[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      checkIdle("async_reset", 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checkOutput("no_done_after_abort", int'(done[0]), 0);
      end
      applyStimulus('{0, IDEAL, 0, 0, 1'b0});

      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
